// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the ALU arbiter. Holds the ALU control
//               codes, the shift-source select bit, the arbiter FSM state
//               encodings and the bit positions inside the captured flags.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // Operation codes carried in ctrl[2:0]; the arbiter passes them through.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_NEG  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_SLL  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_SRA  = 3'b110,
    ALU_DIFF = 3'b111
  } alu_op_e;

  // ctrl bit that selects the immediate shamt as the shift source.
  localparam int ALU_SHAMT_SEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Bit positions inside rsp_flags = {carry, neg, zero}.
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_ZERO  = 0;

  function automatic logic alu_uses_shamt(input logic [3:0] ctrl);
    return ctrl[ALU_SHAMT_SEL];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant. A single request is granted
//               directly; when both request, the pointer decides. On an
//               accepted grant the pointer moves to the other requester.
// Ports       : clk, rst (sync, active-low)
//               i_req[1:0]   request vector
//               i_accept     the current grant was taken this cycle
//               o_gnt[1:0]   one-hot grant (zero when nothing requests)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // Pointer becomes ~owner; owner is 0 exactly when o_gnt[0] is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters. One
//               operation is accepted at a time (valid/ready), its operands
//               are registered onto the ALU, held for SETTLE_CYC cycles, and
//               the result and flags are captured and returned to the owner
//               through a per-requester response handshake.
// Ports       : clk, rst (sync, active-low)
//               i_reqN_valid/o_reqN_ready, i_reqN_inp1/inp2/shamt/ctrl
//               o_alu_inp1/inp2/shamt/ctrl  -> ALU
//               i_alu_out, i_alu_carry/neg/zero <- ALU
//               o_rspN_valid/i_rspN_ready, o_rsp_data, o_rsp_flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_inp1,
  input  logic [DATA_W-1:0] i_req0_inp2,
  input  logic [4:0]        i_req0_shamt,
  input  logic [3:0]        i_req0_ctrl,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_inp1,
  input  logic [DATA_W-1:0] i_req1_inp2,
  input  logic [4:0]        i_req1_shamt,
  input  logic [3:0]        i_req1_ctrl,
  output logic [DATA_W-1:0] o_alu_inp1,
  output logic [DATA_W-1:0] o_alu_inp2,
  output logic [4:0]        o_alu_shamt,
  output logic [3:0]        o_alu_ctrl,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_carry,
  input  logic              i_alu_neg,
  input  logic              i_alu_zero,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  input  logic              i_rsp0_ready,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [2:0]        o_rsp_flags
);

  localparam logic [3:0] c_cnt_init = 4'(SETTLE_CYC - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_owner;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_alu_inp1;
  logic [DATA_W-1:0] r_alu_inp2;
  logic [4:0]        r_alu_shamt;
  logic [3:0]        r_alu_ctrl;
  logic [DATA_W-1:0] r_rsp_data;
  logic [2:0]        r_rsp_flags;

  logic [1:0]        w_gnt;
  logic [1:0]        w_ready;
  logic              w_accept;
  logic              w_rsp_ack;
  logic [2:0]        w_flags;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({i_req1_valid, i_req0_valid}),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  // Ready is also held low while reset is asserted so nothing looks accepted
  // during a reset hold.
  assign w_ready   = (rst && (r_state == ST_IDLE)) ? w_gnt : 2'b00;
  assign w_accept  = |w_ready;
  // Only the owner's response ready matters.
  assign w_rsp_ack = r_owner ? i_rsp1_ready : i_rsp0_ready;

  always_comb begin
    w_flags             = 3'b000;
    w_flags[FLAG_CARRY] = i_alu_carry;
    w_flags[FLAG_NEG]   = i_alu_neg;
    w_flags[FLAG_ZERO]  = i_alu_zero;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)         w_state_nxt = ST_EXEC;
      ST_EXEC: if (r_cnt == 4'd0)    w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_ack)        w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand, counter and response registers. ALU operands change only on
  // accept, so the ALU sees stable inputs through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_owner     <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_alu_inp1  <= '0;
      r_alu_inp2  <= '0;
      r_alu_shamt <= '0;
      r_alu_ctrl  <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_ready[1]) begin
              r_alu_inp1  <= i_req1_inp1;
              r_alu_inp2  <= i_req1_inp2;
              r_alu_shamt <= i_req1_shamt;
              r_alu_ctrl  <= i_req1_ctrl;
            end else begin
              r_alu_inp1  <= i_req0_inp1;
              r_alu_inp2  <= i_req0_inp2;
              r_alu_shamt <= i_req0_shamt;
              r_alu_ctrl  <= i_req0_ctrl;
            end
            r_owner <= w_ready[1];
            r_cnt   <= c_cnt_init;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_data           <= i_alu_out;
            r_rsp_flags          <= w_flags;
            r_rsp_valid[r_owner] <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (w_rsp_ack) begin
            r_rsp_valid <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req0_ready = w_ready[0];
  assign o_req1_ready = w_ready[1];
  assign o_alu_inp1   = r_alu_inp1;
  assign o_alu_inp2   = r_alu_inp2;
  assign o_alu_shamt  = r_alu_shamt;
  assign o_alu_ctrl   = r_alu_ctrl;
  assign o_rsp0_valid = r_rsp_valid[0];
  assign o_rsp1_valid = r_rsp_valid[1];
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_flags  = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Bench for alu_arbiter. Two instances (settle 1 and settle 4)
//               each drive a behavioural ALU. A scoreboard queue per instance
//               holds the expected response of every accepted operation; a
//               monitor compares outputs against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int          DW = 32;
  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [3:0]  ctrl;
  } ops_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [2][2];
  logic        req_ready [2][2];
  logic [31:0] req_inp1  [2][2];
  logic [31:0] req_inp2  [2][2];
  logic [4:0]  req_shamt [2][2];
  logic [3:0]  req_ctrl  [2][2];
  logic        rsp_valid [2][2];
  logic        rsp_ready [2][2];
  logic [31:0] alu_inp1  [2];
  logic [31:0] alu_inp2  [2];
  logic [4:0]  alu_shamt [2];
  logic [3:0]  alu_ctrl  [2];
  logic [34:0] alu_res   [2];
  logic [31:0] rsp_data  [2];
  logic [2:0]  rsp_flags [2];

  int n_checks = 0;
  int n_errors = 0;

  exp_t        q     [2][$];
  ops_t        m_alu [2];
  logic        m_ptr [2];
  int unsigned m_acc [2];
  int          glog  [$];

  // Behavioural ALU: returns {carry, neg, zero, result}; neg/zero describe inp1.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [3:0] ctrl);
    logic [32:0] w;
    logic [4:0]  amt;
    logic [31:0] y;
    logic        c;
    amt = alu_uses_shamt(ctrl) ? sh : b[4:0];
    c   = 1'b0;
    w   = '0;
    case (alu_op_e'(ctrl[2:0]))
      ALU_ADD:  begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32]; end
      ALU_NEG:  y = 32'd0 - b;
      ALU_AND:  y = a & b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << amt;
      ALU_SRL:  y = a >> amt;
      ALU_SRA:  y = $unsigned($signed(a) >>> amt);
      ALU_DIFF: begin w = {1'b0, a} - {1'b0, b}; y = w[31:0]; c = w[32]; end
      default:  y = '0;
    endcase
    return {c, a[31], (a == 32'd0), y};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    alu_arbiter #(
      .DATA_W     (DW),
      .SETTLE_CYC ((d == 0) ? int'(S0) : int'(S1))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_req0_valid (req_valid[d][0]),
      .o_req0_ready (req_ready[d][0]),
      .i_req0_inp1  (req_inp1[d][0]),
      .i_req0_inp2  (req_inp2[d][0]),
      .i_req0_shamt (req_shamt[d][0]),
      .i_req0_ctrl  (req_ctrl[d][0]),
      .i_req1_valid (req_valid[d][1]),
      .o_req1_ready (req_ready[d][1]),
      .i_req1_inp1  (req_inp1[d][1]),
      .i_req1_inp2  (req_inp2[d][1]),
      .i_req1_shamt (req_shamt[d][1]),
      .i_req1_ctrl  (req_ctrl[d][1]),
      .o_alu_inp1   (alu_inp1[d]),
      .o_alu_inp2   (alu_inp2[d]),
      .o_alu_shamt  (alu_shamt[d]),
      .o_alu_ctrl   (alu_ctrl[d]),
      .i_alu_out    (alu_res[d][31:0]),
      .i_alu_carry  (alu_res[d][34]),
      .i_alu_neg    (alu_res[d][33]),
      .i_alu_zero   (alu_res[d][32]),
      .o_rsp0_valid (rsp_valid[d][0]),
      .o_rsp1_valid (rsp_valid[d][1]),
      .i_rsp0_ready (rsp_ready[d][0]),
      .i_rsp1_ready (rsp_ready[d][1]),
      .o_rsp_data   (rsp_data[d]),
      .o_rsp_flags  (rsp_flags[d])
    );
    assign alu_res[d] = alu_fn(alu_inp1[d], alu_inp2[d], alu_shamt[d], alu_ctrl[d]);
  end

  task automatic chk(input string name, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Transaction model: an accepted operation becomes visible S cycles later on
  // its owner's response and stays until the owner takes it.
  task automatic monitor();
    int unsigned cyc;
    int unsigned s;
    logic        busy, vis, own, k;
    logic [1:0]  v, er;
    logic [34:0] res;
    exp_t        e;
    ops_t        o;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        s    = (d == 0) ? S0 : S1;
        busy = (q[d].size() != 0);
        own  = busy ? q[d][0].owner : 1'b0;
        vis  = busy && (cyc >= m_acc[d] + s);
        chk("alu_regs", d, 128'({alu_inp1[d], alu_inp2[d], alu_shamt[d], alu_ctrl[d]}),
            128'(m_alu[d]));
        for (int r = 0; r < 2; r++) begin
          chk("rsp_valid", d, 128'(rsp_valid[d][r]), 128'(vis && (own == 1'(r))));
        end
        if (rsp_valid[d][0] === 1'b1 || rsp_valid[d][1] === 1'b1) begin
          if (!busy) begin
            chk("rsp_unexpected", d, 128'(1), 128'(0));
          end else begin
            e = q[d][0];
            chk("rsp_data", d, 128'(rsp_data[d]), 128'(e.data));
            chk("rsp_flags", d, 128'(rsp_flags[d]), 128'(e.flags));
          end
        end
        v  = {req_valid[d][1], req_valid[d][0]};
        er = 2'b00;
        if (rst && !busy) begin
          er = (v == 2'b11) ? (m_ptr[d] ? 2'b10 : 2'b01) : v;
        end
        chk("req_ready", d, 128'({req_ready[d][1], req_ready[d][0]}), 128'(er));
        if (!rst) begin
          q[d].delete();
          m_alu[d] = '0;
          m_ptr[d] = 1'b0;
        end else if (vis && rsp_ready[d][own]) begin
          void'(q[d].pop_front());
        end else if (er != 2'b00) begin
          k = er[1];
          o.a = req_inp1[d][k]; o.b = req_inp2[d][k];
          o.sh = req_shamt[d][k]; o.ctrl = req_ctrl[d][k];
          res     = alu_fn(o.a, o.b, o.sh, o.ctrl);
          e.owner = k;
          e.data  = res[31:0];
          e.flags = res[34:32];
          q[d].push_back(e);
          m_alu[d] = o;
          m_ptr[d] = ~k;
          m_acc[d] = cyc + 1;
          if (d == 0) glog.push_back(int'(k));
        end
      end
    end
  endtask

  task automatic set_ops(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] ctrl);
    req_inp1[d][r] = a; req_inp2[d][r] = b; req_shamt[d][r] = sh; req_ctrl[d][r] = ctrl;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int d, input int r);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[d][r] === 1'b1) break;
    end
    chk("accept_seen", d, 128'(k < 20), 128'(1));
    step(1);
  endtask

  task automatic wait_rsp(input int d, input int r, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (rsp_valid[d][r] === 1'b1) break;
      lat++;
    end
    chk("rsp_seen", d, 128'(lat < 40), 128'(1));
  endtask

  initial begin
    int lat;
    int nlog;
    for (int d = 0; d < 2; d++) begin
      m_alu[d] = '0; m_ptr[d] = 1'b0; m_acc[d] = 0;
      for (int r = 0; r < 2; r++) begin
        req_valid[d][r] = 1'b0; rsp_ready[d][r] = 1'b1;
        set_ops(d, r, 32'd0, 32'd0, 5'd0, 4'd0);
      end
    end
    fork
      monitor();
    join_none

    // Reset hold with both requesting
    set_ops(0, 0, 32'd5, 32'd7, 5'd0, 4'b0000);
    set_ops(0, 1, $urandom, $urandom, 5'd0, 4'b0011);
    req_valid[0][0] = 1'b1; req_valid[0][1] = 1'b1;
    step(3);
    chk("rst_alu_inp1", 0, 128'(alu_inp1[0]), 128'(0));
    chk("rst_rsp_valid", 0, 128'({rsp_valid[0][1], rsp_valid[0][0]}), 128'(0));
    chk("rst_ready", 0, 128'({req_ready[0][1], req_ready[0][0]}), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("first_grant", 0, 128'({req_ready[0][1], req_ready[0][0]}), 128'(2'b01));
    step(1);
    req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
    wait_rsp(0, 0, lat);
    chk("add_latency", 0, 128'(lat), 128'(S0));
    chk("add_data", 0, 128'(rsp_data[0]), 128'(32'd12));
    chk("add_flags", 0, 128'(rsp_flags[0]), 128'(3'b000));
    step(2);

    // Contention: grants must alternate
    nlog = glog.size();
    set_ops(0, 0, $urandom, $urandom, 5'd0, 4'b0111);
    set_ops(0, 1, $urandom, $urandom, 5'd0, 4'b0011);
    req_valid[0][0] = 1'b1; req_valid[0][1] = 1'b1;
    step(24);
    req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
    step(6);
    chk("contention_count", 0, 128'(glog.size() - nlog >= 6), 128'(1));
    for (int i = nlog + 1; i < glog.size(); i++) begin
      chk("grant_alternate", 0, 128'(glog[i]), 128'(1 - glog[i-1]));
    end

    // Backpressure on requester 1
    set_ops(0, 1, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'b0000);
    rsp_ready[0][1] = 1'b0; rsp_ready[0][0] = 1'b0;
    req_valid[0][1] = 1'b1;
    wait_accept(0, 1);
    req_valid[0][1] = 1'b0;
    set_ops(0, 0, $urandom, $urandom, 5'd0, 4'b0000);
    req_valid[0][0] = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_valid", 0, 128'(rsp_valid[0][1]), 128'(1));
      chk("bp_data", 0, 128'(rsp_data[0]), 128'(0));
      chk("bp_carry", 0, 128'(rsp_flags[0][FLAG_CARRY]), 128'(1));
      chk("bp_no_ready", 0, 128'({req_ready[0][1], req_ready[0][0]}), 128'(0));
      step(1);
      rsp_ready[0][0] = ~rsp_ready[0][0];
    end
    rsp_ready[0][0] = 1'b1; rsp_ready[0][1] = 1'b1;
    wait_accept(0, 0);
    req_valid[0][0] = 1'b0;
    step(4);

    // Settle delay of 4 with an immediate-shamt shift
    set_ops(1, 0, 32'd1, $urandom, 5'd3, 4'b1100);
    req_valid[1][0] = 1'b1;
    wait_accept(1, 0);
    req_valid[1][0] = 1'b0;
    req_inp1[1][0] = $urandom;
    wait_rsp(1, 0, lat);
    chk("settle_latency", 1, 128'(lat), 128'(S1));
    chk("settle_data", 1, 128'(rsp_data[1]), 128'(32'd8));
    step(2);

    // Reset during EXEC
    set_ops(1, 1, $urandom, $urandom, 5'($urandom), 4'($urandom));
    req_valid[1][1] = 1'b1;
    wait_accept(1, 1);
    req_valid[1][1] = 1'b0;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    req_valid[1][0] = 1'b1; req_valid[1][1] = 1'b1;
    @(negedge clk);
    chk("exec_rst_valid", 1, 128'({rsp_valid[1][1], rsp_valid[1][0]}), 128'(0));
    chk("exec_rst_grant", 1, 128'({req_ready[1][1], req_ready[1][0]}), 128'(2'b01));
    step(1);
    req_valid[1][0] = 1'b0; req_valid[1][1] = 1'b0;
    step(10);

    // Reset during RESP
    set_ops(0, 1, $urandom, $urandom, 5'($urandom), 4'($urandom));
    rsp_ready[0][1] = 1'b0;
    req_valid[0][1] = 1'b1;
    wait_accept(0, 1);
    req_valid[0][1] = 1'b0;
    wait_rsp(0, 1, lat);
    step(1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    rsp_ready[0][1] = 1'b1;
    req_valid[0][0] = 1'b1; req_valid[0][1] = 1'b1;
    @(negedge clk);
    chk("resp_rst_valid", 0, 128'({rsp_valid[0][1], rsp_valid[0][0]}), 128'(0));
    chk("resp_rst_grant", 0, 128'({req_ready[0][1], req_ready[0][0]}), 128'(2'b01));
    step(1);
    req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
    step(6);

    // Randomized traffic on both instances
    repeat (400) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          req_valid[d][r] = 1'($urandom_range(0, 1));
          set_ops(d, r, $urandom, $urandom, 5'($urandom), 4'($urandom));
          rsp_ready[d][r] = ($urandom_range(0, 3) != 0);
        end
      end
      step(1);
    end
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        req_valid[d][r] = 1'b0; rsp_ready[d][r] = 1'b1;
      end
    end
    step(12);
    chk("drain", 0, 128'(q[0].size()), 128'(0));
    chk("drain", 1, 128'(q[1].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
